// File: rtl/digit_scan_if.sv
// Handshake/config bundle between a scan controller and the digit select sequencer.
interface digit_scan_if #(parameter int CNT_W = 16);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] dwell;
  logic [7:0]       mask;
  logic [2:0]       sel;
  logic             sel_en;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, stop, dwell, mask,
    input  sel, sel_en, busy, frame_done
  );

  modport slave (
    input  start, stop, dwell, mask,
    output sel, sel_en, busy, frame_done
  );
endinterface

// File: rtl/digit_scan_sequencer.sv
// Steps a 3-8 decoder select through the enabled positions of a mask, with a
// programmable dwell per position and a decoder-disabled blanking gap between positions.
//
//   state  | meaning
//   IDLE   | not scanning, decoder disabled, sel parked at 0
//   BLANK  | decoder disabled while sel settles on the next position
//   ACTIVE | decoder enabled on sel for the latched dwell time
module digit_scan_sequencer #(
  parameter int CNT_W = 16,
  parameter int BLANK = 2
) (
  input logic        clk,
  input logic        rst_n,
  digit_scan_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             sel_en_q, sel_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic [CNT_W-1:0] dwell_load;
  logic [2:0]       first_pos;
  logic [2:0]       next_pos;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Scan from the far end back toward cur+1 so the nearest enabled position wins;
  // cur itself is the last resort, which covers a single-bit mask.
  function automatic logic [2:0] search_from(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] p;
    logic [2:0] r;
    r = cur;
    for (int k = 8; k >= 1; k--) begin
      p = cur + 3'(k);
      if (m[p]) r = p;
    end
    return r;
  endfunction

  always_comb begin
    dwell_load = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
    first_pos  = lowest_set(bus.mask);
    next_pos   = search_from(bus.mask, sel_q);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.mask != 8'h00)) begin
          state_d = ST_BLANK;
          sel_d   = first_pos;
          cnt_d   = BLANK_LOAD;
        end
      end
      ST_BLANK: begin
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = dwell_load;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == '0) begin
          if (bus.mask == 8'h00) begin
            state_d = ST_IDLE;
            sel_d   = 3'd0;
            cnt_d   = '0;
          end else begin
            state_d      = ST_BLANK;
            sel_d        = next_pos;
            cnt_d        = BLANK_LOAD;
            frame_done_d = (next_pos <= sel_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides everything, including a frame_done that would have fired.
    if (bus.stop) begin
      state_d      = ST_IDLE;
      sel_d        = 3'd0;
      cnt_d        = '0;
      frame_done_d = 1'b0;
    end

    sel_en_d = (state_d == ST_ACTIVE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      sel_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      sel_en_q     <= sel_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_en     = sel_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
